average_divider: RTL
====================

AVERAGE_DIVIDER -- requirements
Module: average_divider

Interface
- REQ-001: Parameter SIZE_DATA, default 16, sets the width of the averaged output sample.
- REQ-002: Parameter SIZE_MAX_WINDOW, default 64, sets the largest legal window length.
- REQ-003: Parameter SIZE_SUM, default SIZE_DATA + $clog2(SIZE_MAX_WINDOW) = 22, sets the width of the incoming window sum.
- REQ-004: Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
- REQ-005: Port reset_n, input, 1 bit, is the asynchronous active-low reset.
- REQ-006: Port sum_in, input, SIZE_SUM bits, carries the signed two's-complement window sum from the moving-average accumulator.
- REQ-007: Port window_size, input, $clog2(SIZE_MAX_WINDOW)+1 bits, carries the unsigned divisor (legal range 1..SIZE_MAX_WINDOW).
- REQ-008: Port sum_valid, input, 1 bit, indicates that sum_in and window_size are valid.
- REQ-009: Port sum_ready, output, 1 bit, indicates that the block can accept a sum.
- REQ-010: Port avg_out, output, SIZE_DATA bits, carries the signed average.
- REQ-011: Port avg_valid, output, 1 bit, indicates that avg_out is valid.
- REQ-012: Port avg_ready, input, 1 bit, indicates that downstream accepts avg_out.
- REQ-013: Port div_error, output, 1 bit, is qualified by avg_valid and flags an illegal window_size.

Function
- REQ-014: The block SHALL be an FSM with the states IDLE, DIVIDE and DONE.
- REQ-015: In IDLE, sum_ready SHALL be 1; in DIVIDE and DONE, sum_ready SHALL be 0.
- REQ-016: Accept occurs on an edge where IDLE && sum_valid. At that edge the block SHALL capture |sum_in|, the sign of sum_in and window_size, clear the iteration counter, and go to DIVIDE.
- REQ-017: Inputs that change after the accept edge SHALL have no effect on the result.
- REQ-018: DIVIDE SHALL perform a restoring unsigned division, one quotient bit per cycle, MSB first, for exactly SIZE_SUM cycles.
- REQ-019: The transition DIVIDE->DONE SHALL occur on the 22nd edge after accept, so avg_valid rises exactly SIZE_SUM cycles after the accepting edge.
- REQ-020: Quotient rounding SHALL be truncation toward zero: negate the magnitude quotient if the captured sign is 1.
- REQ-021: A signed result outside the SIZE_DATA range SHALL saturate to +32767 or -32768.
- REQ-022: If the captured window_size is 0 or greater than SIZE_MAX_WINDOW, DIVIDE SHALL still take SIZE_SUM cycles, avg_out SHALL be 0 and div_error SHALL be 1; otherwise div_error SHALL be 0.
- REQ-023: DONE SHALL hold avg_valid=1 with stable avg_out and div_error until avg_ready=1.
- REQ-024: On the edge where DONE && avg_ready, the block SHALL go to IDLE and deassert avg_valid; the next accept can occur no earlier than the following edge. Throughput is therefore 1 result per SIZE_SUM+2 cycles minimum.
- REQ-025: avg_out and div_error SHALL be registered and SHALL change only on the DIVIDE->DONE edge.
- REQ-026: A sum_in of 0 SHALL yield avg_out=0 with no negative-zero artefacts.

Reset
- REQ-027: While reset_n=0, independent of clk, state SHALL be IDLE, sum_ready=1, avg_valid=0, avg_out=0, div_error=0, and all internal registers SHALL be cleared.
- REQ-028: Reset asserted in DIVIDE or DONE SHALL abandon the operation; no result for it SHALL ever be presented.
- REQ-029: After reset_n deasserts, the first accept is permitted on the first rising edge.

Verification
- REQ-030: sum_in=700, window_size=7, avg_ready=1 -> avg_valid at accept+22 cycles, avg_out=100, div_error=0, sum_ready=1 one cycle later.
- REQ-031: sum_in=-700, window_size=7 -> avg_out=-100 (0xFF9C); sum_in=-10, window_size=3 -> avg_out=-3 (truncation toward zero).
- REQ-032: sum_in=0x1FFFFF, window_size=1 -> avg_out=32767; sum_in=0x200000, window_size=1 -> avg_out=-32768.
- REQ-033: window_size=0 and window_size=65 -> avg_out=0, div_error=1, latency unchanged at 22 cycles.
- REQ-034: avg_ready held 0 for 5 cycles in DONE, with sum_valid=1 and a new sum_in -> avg_out stable, sum_ready=0, and the new sum accepted only after the avg_ready handshake.
- REQ-035: reset_n pulsed low at accept+10 cycles -> outputs at the reset values immediately, no avg_valid for the abandoned sum, and the next sum (64*-5=-320, window_size=64) -> avg_out=-5.

Source files
------------

// File: rtl/average_divider.sv
// Signed window-sum divider: restoring unsigned division on the magnitude,
// one quotient bit per cycle, with sign restore, saturation and illegal-window flagging.
module average_divider #(
  parameter int SIZE_DATA       = 16,
  parameter int SIZE_MAX_WINDOW = 64,
  parameter int SIZE_SUM        = SIZE_DATA + $clog2(SIZE_MAX_WINDOW)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [SIZE_SUM-1:0]                sum_in,
  input  logic [$clog2(SIZE_MAX_WINDOW):0]   window_size,
  input  logic                               sum_valid,
  output logic                               sum_ready,
  output logic [SIZE_DATA-1:0]               avg_out,
  output logic                               avg_valid,
  input  logic                               avg_ready,
  output logic                               div_error
);

  localparam int WIN_W = $clog2(SIZE_MAX_WINDOW) + 1;
  localparam int REM_W = WIN_W + 1;
  localparam int CNT_W = $clog2(SIZE_SUM);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(SIZE_SUM - 1);
  localparam logic [WIN_W-1:0]     WIN_MAX  = WIN_W'(SIZE_MAX_WINDOW);
  localparam logic [SIZE_SUM-1:0]  POS_LIM  = SIZE_SUM'((2 ** (SIZE_DATA - 1)) - 1);
  localparam logic [SIZE_SUM-1:0]  NEG_LIM  = SIZE_SUM'(2 ** (SIZE_DATA - 1));
  localparam logic [SIZE_DATA-1:0] MAX_POS  = {1'b0, {(SIZE_DATA-1){1'b1}}};
  localparam logic [SIZE_DATA-1:0] MIN_NEG  = {1'b1, {(SIZE_DATA-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [SIZE_SUM-1:0]  dvd_r;
  logic [REM_W-1:0]     rem_r;
  logic [WIN_W-1:0]     div_r;
  logic                 neg_r;
  logic                 err_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [SIZE_DATA-1:0] avg_r;
  logic                 div_error_r;
  logic                 sum_ready_r;
  logic                 avg_valid_r;

  logic [REM_W-1:0]     rem_shift_s;
  logic [REM_W-1:0]     rem_nxt_s;
  logic                 qbit_s;
  logic [SIZE_SUM-1:0]  dvd_nxt_s;
  logic [SIZE_SUM-1:0]  abs_s;
  logic                 win_bad_s;
  logic [SIZE_DATA-1:0] result_s;

  // Applies the captured sign to the magnitude quotient and clamps to the output range.
  function automatic logic [SIZE_DATA-1:0] saturate(input logic [SIZE_SUM-1:0] mag,
                                                    input logic                neg);
    logic [SIZE_DATA-1:0] low;
    low = mag[SIZE_DATA-1:0];
    if (neg) begin
      if (mag > NEG_LIM) return MIN_NEG;
      else               return ~low + SIZE_DATA'(1);
    end else begin
      if (mag > POS_LIM) return MAX_POS;
      else               return low;
    end
  endfunction

  // One restoring-division step plus input magnitude/legality decode.
  always_comb begin
    rem_shift_s = {rem_r[REM_W-2:0], dvd_r[SIZE_SUM-1]};
    qbit_s      = (rem_shift_s >= {1'b0, div_r});
    if (qbit_s) rem_nxt_s = rem_shift_s - {1'b0, div_r};
    else        rem_nxt_s = rem_shift_s;
    dvd_nxt_s   = {dvd_r[SIZE_SUM-2:0], qbit_s};
    if (sum_in[SIZE_SUM-1]) abs_s = ~sum_in + SIZE_SUM'(1);
    else                    abs_s = sum_in;
    win_bad_s   = (window_size == WIN_W'(0)) || (window_size > WIN_MAX);
    if (err_r) result_s = SIZE_DATA'(0);
    else       result_s = saturate(dvd_nxt_s, neg_r);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (sum_valid) state_nxt_s = DIVIDE; else state_nxt_s = IDLE;
      DIVIDE:  if (cnt_r == LAST_CNT) state_nxt_s = DONE; else state_nxt_s = DIVIDE;
      DONE:    if (avg_ready) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      sum_ready_r <= 1'b1;
      avg_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sum_ready_r <= (state_nxt_s == IDLE);
      avg_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, division iterations and result latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_r       <= '0;
      rem_r       <= '0;
      div_r       <= '0;
      neg_r       <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= '0;
      avg_r       <= '0;
      div_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sum_valid) begin
            dvd_r <= abs_s;
            rem_r <= '0;
            div_r <= window_size;
            neg_r <= sum_in[SIZE_SUM-1];
            err_r <= win_bad_s;
            cnt_r <= '0;
          end
        end
        DIVIDE: begin
          dvd_r <= dvd_nxt_s;
          rem_r <= rem_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            avg_r       <= result_s;
            div_error_r <= err_r;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign sum_ready = sum_ready_r;
  assign avg_valid = avg_valid_r;
  assign avg_out   = avg_r;
  assign div_error = div_error_r;

endmodule
